// File: rtl/fpga1_dual_link_wrapper.sv
// fpga1_dual_link_wrapper: two independent 16-bit framed serial lanes.
// Each lane sends IDLE frames until its receiver locks, then sends sequenced data frames.
module fpga1_dual_link_lane #(
    parameter int          LOCK_COUNT   = 8,
    parameter int          ERR_LIMIT    = 4,
    parameter logic [11:0] IDLE_PAYLOAD = 12'hBC5
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rxp,
    output logic o_txp,
    output logic o_up
);
    localparam logic [15:0] IDLE = {4'b1010, IDLE_PAYLOAD};
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, UP} state_t;

    logic [3:0]    r_idx;
    logic [15:0]   r_frame;
    logic [11:0]   r_seq;
    logic          r_txp;
    logic [15:0]   r_sr;
    logic [3:0]    r_bcnt;
    state_t        r_state;
    logic [GW-1:0] r_good;
    logic [EW-1:0] r_bad;
    logic          r_up;
    logic          w_boundary;
    logic          w_check;
    logic          w_valid;
    logic [15:0]   w_next_frame;

    assign w_boundary   = r_idx == 4'd15;
    assign w_next_frame = r_up ? {4'b0101, r_seq} : IDLE;
    assign w_check      = r_bcnt == 4'd15;
    assign w_valid      = (r_sr[15:12] == 4'b1010) || (r_sr[15:12] == 4'b0101);
    assign o_txp        = r_txp;
    assign o_up         = r_up;

    // Frame type is latched only at the boundary, so a frame in progress always completes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx   <= 4'd15;
            r_frame <= IDLE;
            r_seq   <= 12'd0;
            r_txp   <= 1'b0;
        end else begin
            r_idx <= r_idx - 4'd1;
            r_txp <= w_boundary ? w_next_frame[15] : r_frame[r_idx];
            if (w_boundary)
                r_frame <= w_next_frame;
            if (!r_up)
                r_seq <= 12'd0;
            else if (w_boundary)
                r_seq <= r_seq + 12'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr    <= 16'd0;
            r_bcnt  <= 4'd0;
            r_state <= HUNT;
            r_good  <= '0;
            r_bad   <= '0;
            r_up    <= 1'b0;
        end else begin
            r_sr   <= {r_sr[14:0], i_rxp};
            r_bcnt <= r_bcnt + 4'd1;
            r_up   <= r_state == UP;
            case (r_state)
                HUNT:
                    if (r_sr == IDLE) begin
                        r_bcnt  <= 4'd0;
                        r_good  <= '0;
                        r_state <= VERIFY;
                    end
                VERIFY:
                    if (w_check) begin
                        if (!w_valid)
                            r_state <= HUNT;
                        else if (r_good == GW'(LOCK_COUNT - 1)) begin
                            r_bad   <= '0;
                            r_state <= UP;
                        end else
                            r_good <= r_good + GW'(1);
                    end
                UP:
                    if (w_check) begin
                        if (w_valid)
                            r_bad <= '0;
                        else if (r_bad == EW'(ERR_LIMIT - 1))
                            r_state <= HUNT;
                        else
                            r_bad <= r_bad + EW'(1);
                    end
                default: r_state <= HUNT;
            endcase
        end
    end
endmodule

module fpga1_dual_link_wrapper #(
    parameter int          LOCK_COUNT   = 8,
    parameter int          ERR_LIMIT    = 4,
    parameter logic [11:0] IDLE_PAYLOAD = 12'hBC5
) (
    input  logic clk_200MHz_p,
    input  logic clk_200MHz_n,
    input  logic peripheral_reset,
    input  logic rxp_0,
    input  logic rxn_0,
    input  logic rxp_1,
    input  logic rxn_1,
    output logic txp_0,
    output logic txn_0,
    output logic txp_1,
    output logic txn_1,
    output logic channel_up_0,
    output logic channel_up_1
);
    logic w_unused;

    assign w_unused = &{1'b0, clk_200MHz_n, rxn_0, rxn_1};
    assign txn_0    = ~txp_0;
    assign txn_1    = ~txp_1;

    fpga1_dual_link_lane #(
        .LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT), .IDLE_PAYLOAD(IDLE_PAYLOAD)
    ) u_lane0 (
        .i_clk(clk_200MHz_p), .i_rst_n(peripheral_reset), .i_rxp(rxp_0),
        .o_txp(txp_0), .o_up(channel_up_0)
    );

    fpga1_dual_link_lane #(
        .LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT), .IDLE_PAYLOAD(IDLE_PAYLOAD)
    ) u_lane1 (
        .i_clk(clk_200MHz_p), .i_rst_n(peripheral_reset), .i_rxp(rxp_1),
        .o_txp(txp_1), .o_up(channel_up_1)
    );
endmodule

// File: tb/tb_fpga1_dual_link_wrapper.sv
// tb_fpga1_dual_link_wrapper: lane 0 in loopback, lane 1 with constant RX input.
`timescale 1ns/1ps
module tb_fpga1_dual_link_wrapper;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic force0 = 1'b0;
    logic rxp_1 = 1'b0;
    logic rxn_1 = 1'b1;
    logic rxp_0, rxn_0, txp_0, txn_0, txp_1, txn_1, up0, up1;
    int cyc = 0;
    int up0_lo = 0;
    int up1_hi = 0;
    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    always #2.5 clk = ~clk;

    assign rxp_0 = force0 ? 1'b0 : txp_0;
    assign rxn_0 = txn_0;

    fpga1_dual_link_wrapper dut (
        .clk_200MHz_p(clk), .clk_200MHz_n(~clk), .peripheral_reset(rst_n),
        .rxp_0(rxp_0), .rxn_0(rxn_0), .rxp_1(rxp_1), .rxn_1(rxn_1),
        .txp_0(txp_0), .txn_0(txn_0), .txp_1(txp_1), .txn_1(txn_1),
        .channel_up_0(up0), .channel_up_1(up1)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && up0 !== 1'b1) up0_lo <= up0_lo + 1;
        if (up1 !== 1'b0) up1_hi <= up1_hi + 1;
    end

    task automatic to_cyc(input int n);
        for (int i = 0; i < 20000 && cyc < n; i++) @(negedge clk);
    endtask

    task automatic to_phase(input int ph);
        for (int i = 0; i < 17 && cyc % 16 != ph; i++) @(negedge clk);
    endtask

    // Pops one expected frame per 16 captured bits; txn is checked every bit.
    task automatic capture_frames(input int lane, input int n, input string name);
        logic [15:0] got, exp;
        int comp_err = 0;
        for (int f = 0; f < n; f++) begin
            got = 16'd0;
            for (int b = 0; b < 16; b++) begin
                @(negedge clk);
                got = {got[14:0], lane == 0 ? txp_0 : txp_1};
                if ((lane == 0 ? txn_0 : txn_1) !== ~(lane == 0 ? txp_0 : txp_1)) comp_err++;
            end
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s frame %0d: got %h expected %h", name, f, got, exp);
            end
        end
        total++;
        if (comp_err !== 0) begin
            bad++;
            $display("FAIL %s txn complement: %0d bad bits expected 0", name, comp_err);
        end
    endtask

    task automatic test_reset();
        #12.3 rst_n = 1'b0;
        #0.5;
        total++;
        if ({txp_0, txn_0, txp_1, txn_1, up0, up1} !== 6'b010100) begin
            bad++;
            $display("FAIL reset_async: outputs %b expected 010100",
                     {txp_0, txn_0, txp_1, txn_1, up0, up1});
        end
        #1000;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_idle_tx();
        exp_q.push_back(16'hABC5);
        exp_q.push_back(16'hABC5);
        capture_frames(1, 2, "idle_lane1");
    endtask

    task automatic test_link_up();
        for (int i = 0; i < 300 && up0 !== 1'b1; i++) @(negedge clk);
        total++;
        if (up0 !== 1'b1 || cyc < 144 || cyc > 200) begin
            bad++;
            $display("FAIL link_up_time: up=%b at clock %0d expected 1 within 144..200", up0, cyc);
        end
    endtask

    task automatic test_data_seq();
        int s;
        to_cyc(160);
        s = up0_lo;
        for (int i = 0; i < 625; i++) exp_q.push_back(16'h5000 + 16'(i));
        capture_frames(0, 625, "data_seq");
        total++;
        if (up0_lo - s !== 0) begin
            bad++;
            $display("FAIL up_stable: %0d low clocks expected 0", up0_lo - s);
        end
    endtask

    task automatic test_err_burst();
        int e, s;
        rxp_1 = 1'b1;
        rxn_1 = 1'b0;
        to_phase(1);
        e = cyc;
        s = up0_lo;
        force0 = 1'b1;
        to_cyc(e + 48);
        force0 = 1'b0;
        to_cyc(e + 250);
        total++;
        if (up0_lo - s !== 0) begin
            bad++;
            $display("FAIL err_burst3: %0d low clocks expected 0", up0_lo - s);
        end
    endtask

    task automatic test_link_drop();
        int e;
        to_phase(1);
        e = cyc;
        force0 = 1'b1;
        for (int i = 0; i < 200 && up0 === 1'b1; i++) @(negedge clk);
        total++;
        if (up0 !== 1'b0 || cyc - e < 48 || cyc - e > 80) begin
            bad++;
            $display("FAIL link_drop: up=%b after %0d clocks expected 0 within 48..80", up0, cyc - e);
        end
        to_phase(0);
        exp_q.push_back(16'hABC5);
        capture_frames(0, 1, "idle_while_down");
        force0 = 1'b0;
        e = cyc;
        for (int i = 0; i < 400 && up0 !== 1'b1; i++) @(negedge clk);
        total++;
        if (up0 !== 1'b1) begin
            bad++;
            $display("FAIL relock: up=%b after %0d clocks expected 1", up0, cyc - e);
        end
    endtask

    task automatic test_mid_reset();
        repeat (37) @(negedge clk);
        #1.3 rst_n = 1'b0;
        #0.2;
        total++;
        if ({txp_0, txn_0, txp_1, txn_1, up0, up1} !== 6'b010100) begin
            bad++;
            $display("FAIL mid_reset_async: outputs %b expected 010100",
                     {txp_0, txn_0, txp_1, txn_1, up0, up1});
        end
        repeat (5) @(negedge clk);
        total++;
        if ({txp_0, txn_0, up0} !== 3'b010) begin
            bad++;
            $display("FAIL mid_reset_hold: outputs %b expected 010", {txp_0, txn_0, up0});
        end
        rst_n = 1'b1;
        exp_q.push_back(16'hABC5);
        exp_q.push_back(16'hABC5);
        capture_frames(0, 2, "idle_after_reset");
    endtask

    task automatic test_lane1_quiet();
        total++;
        if (up1_hi !== 0) begin
            bad++;
            $display("FAIL lane1_quiet: channel_up_1 high %0d clocks expected 0", up1_hi);
        end
    endtask

    initial begin
        test_reset();
        test_idle_tx();
        test_link_up();
        test_data_seq();
        test_err_burst();
        test_link_drop();
        test_mid_reset();
        test_lane1_quiet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
